sram_bank_ctrl: RTL and testbench

Sits between the AXI4 SRAM slave's single memory port and an array of 4 KB register-file SRAM banks (512 x 64). Decodes each word request to one bank, returns read data with one-cycle latency through a registered bank-select mux, and flags out-of-range accesses. Puts idle banks into light-sleep and wakes them on demand, stalling the upstream port with a grant handshake while a bank wakes.

---
 rtl/sram_bank_ctrl.sv | 108 ++++++++++
 tb/tb_sram_bank_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: word-request decoder onto SRAM banks with light-sleep and wake stall
module sram_bank_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BANK_NUM     = 4,
  parameter int BANK_DEPTH   = 512,
  parameter int SLEEP_CYCLES = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             en_i,
  input  logic                             wen_i,
  input  logic [DATA_WIDTH/8-1:0]          bm_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  output logic                             gnt_o,
  output logic                             rvalid_o,
  output logic [DATA_WIDTH-1:0]            dat_o,
  output logic                             err_o,
  output logic [BANK_NUM-1:0]              bank_en_o,
  output logic                             bank_wen_o,
  output logic [DATA_WIDTH/8-1:0]          bank_bm_o,
  output logic [$clog2(BANK_DEPTH)-1:0]    bank_addr_o,
  output logic [DATA_WIDTH-1:0]            bank_wdat_o,
  input  logic [BANK_NUM*DATA_WIDTH-1:0]   bank_rdat_i,
  output logic [BANK_NUM-1:0]              bank_ls_o
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int RW  = $clog2(BANK_DEPTH);
  localparam int BW  = BANK_NUM > 1 ? $clog2(BANK_NUM) : 1;
  localparam int CW  = SLEEP_CYCLES > 1 ? $clog2(SLEEP_CYCLES) : 1;

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_t;

  logic [ADDR_WIDTH-1:0] w_word, w_bank;
  logic [BW-1:0]         w_sel;
  logic                  w_oor, w_acc;
  logic [BANK_NUM-1:0]   w_active, w_hit;
  logic [DATA_WIDTH-1:0] w_rdat [BANK_NUM];
  logic                  r_rd, r_oor, r_err;
  logic [BW-1:0]         r_sel;

  assign w_word      = addr_i >> OFF;
  assign w_bank      = w_word >> RW;
  assign w_oor       = w_bank >= ADDR_WIDTH'(BANK_NUM);
  assign w_sel       = w_bank[BW-1:0];
  assign gnt_o       = !en_i || w_oor || w_active[w_sel];
  assign w_acc       = en_i && gnt_o;
  assign bank_wen_o  = wen_i;
  assign bank_bm_o   = bm_i;
  assign bank_addr_o = w_word[RW-1:0];
  assign bank_wdat_o = dat_i;
  assign rvalid_o    = r_rd;
  assign err_o       = r_err;
  assign dat_o       = (r_rd && !r_oor) ? w_rdat[r_sel] : '0;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    state_t        r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_ncnt;
    assign w_rdat[b]    = bank_rdat_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign w_hit[b]     = !w_oor && (w_sel == BW'(b));
    assign bank_en_o[b] = w_acc && w_hit[b];
    assign w_active[b]  = r_state == ACTIVE;
    assign bank_ls_o[b] = r_state == SLEEP;
    // bank power state and idle counter
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_state <= ACTIVE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_nstate;
        r_cnt   <= w_ncnt;
      end
    end
    // an enable always beats the sleep threshold; a wake completes even if en_i drops
    always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      case (r_state)
        ACTIVE: begin
          if (bank_en_o[b]) w_ncnt = '0;
          else if (SLEEP_CYCLES != 0 && r_cnt == CW'(SLEEP_CYCLES - 1)) w_nstate = SLEEP;
          else if (r_cnt != '1) w_ncnt = r_cnt + 1'b1;
        end
        SLEEP: w_nstate = (en_i && w_hit[b]) ? WAKE : SLEEP;
        default: begin
          w_nstate = ACTIVE;
          w_ncnt   = '0;
        end
      endcase
    end
  end

  // one-cycle read response and out-of-range pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd  <= 1'b0;
      r_oor <= 1'b0;
      r_err <= 1'b0;
      r_sel <= '0;
    end else begin
      r_rd  <= w_acc && !wen_i;
      r_oor <= w_oor;
      r_err <= w_acc && w_oor;
      r_sel <= w_sel;
    end
  end
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: directed checks of decode, read response, OOR, sleep/wake and reset
module tb_sram_bank_ctrl;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         en_i = 1'b0;
  logic         wen_i = 1'b0;
  logic [7:0]   bm_i = '0;
  logic [31:0]  addr_i = '0;
  logic [63:0]  dat_i = '0;
  logic         gnt_o, rvalid_o, err_o, bank_wen_o;
  logic [63:0]  dat_o, bank_wdat_o;
  logic [3:0]   bank_en_o, bank_ls_o;
  logic [7:0]   bank_bm_o;
  logic [8:0]   bank_addr_o;
  logic [255:0] bank_rdat_i;
  int tests = 0;
  int fails = 0;

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h2222_AAAA_5555_0002;
  localparam logic [63:0] D3 = 64'h3333_CCCC_7777_0003;

  sram_bank_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .wen_i(wen_i), .bm_i(bm_i),
    .addr_i(addr_i), .dat_i(dat_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .dat_o(dat_o),
    .err_o(err_o), .bank_en_o(bank_en_o), .bank_wen_o(bank_wen_o), .bank_bm_o(bank_bm_o),
    .bank_addr_o(bank_addr_o), .bank_wdat_o(bank_wdat_o), .bank_rdat_i(bank_rdat_i),
    .bank_ls_o(bank_ls_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    en_i = 1'b0;
    cyc();
    cyc();
    aresetn = 1'b1;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [63:0] d);
    en_i = 1'b1;
    wen_i = w;
    addr_i = a;
    dat_i = d;
    bm_i = 8'hFF;
    #1;
  endtask

  initial begin
    bank_rdat_i = {D3, D2, D1, D0};
    #1;
    chk("rst_ls", 64'(bank_ls_o), 64'h0);
    chk("rst_gnt", 64'(gnt_o), 64'h1);
    chk("rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_dat", dat_o, 64'h0);
    chk("rst_en", 64'(bank_en_o), 64'h0);
    do_reset();

    req(1'b0, 32'h0000_0008, 64'h0);
    chk("rd0_gnt", 64'(gnt_o), 64'h1);
    chk("rd0_en", 64'(bank_en_o), 64'h1);
    chk("rd0_row", 64'(bank_addr_o), 64'h1);
    cyc();
    en_i = 1'b0;
    #1;
    chk("rd0_rvalid", 64'(rvalid_o), 64'h1);
    chk("rd0_dat", dat_o, D0);
    chk("rd0_err", 64'(err_o), 64'h0);
    cyc();
    #1;
    chk("rd0_rvalid_drop", 64'(rvalid_o), 64'h0);
    chk("rd0_dat_drop", dat_o, 64'h0);

    req(1'b1, 32'h0000_1008, 64'hCAFE_F00D_1234_5678);
    chk("wr1_en", 64'(bank_en_o), 64'h2);
    chk("wr1_wen", 64'(bank_wen_o), 64'h1);
    chk("wr1_row", 64'(bank_addr_o), 64'h1);
    chk("wr1_wdat", bank_wdat_o, 64'hCAFE_F00D_1234_5678);
    chk("wr1_bm", 64'(bank_bm_o), 64'hFF);
    cyc();
    req(1'b0, 32'h0000_3FF8, 64'h0);
    chk("wr1_no_rvalid", 64'(rvalid_o), 64'h0);
    chk("rd3_en", 64'(bank_en_o), 64'h8);
    chk("rd3_wen", 64'(bank_wen_o), 64'h0);
    chk("rd3_row", 64'(bank_addr_o), 64'd511);
    cyc();
    en_i = 1'b0;
    #1;
    chk("rd3_rvalid", 64'(rvalid_o), 64'h1);
    chk("rd3_dat", dat_o, D3);

    req(1'b0, 32'h0000_4000, 64'h0);
    chk("oor_rd_gnt", 64'(gnt_o), 64'h1);
    chk("oor_rd_en", 64'(bank_en_o), 64'h0);
    cyc();
    req(1'b1, 32'h0000_4000, 64'h0);
    chk("oor_rd_rvalid", 64'(rvalid_o), 64'h1);
    chk("oor_rd_err", 64'(err_o), 64'h1);
    chk("oor_rd_dat", dat_o, 64'h0);
    chk("oor_wr_gnt", 64'(gnt_o), 64'h1);
    chk("oor_wr_en", 64'(bank_en_o), 64'h0);
    cyc();
    en_i = 1'b0;
    #1;
    chk("oor_wr_err", 64'(err_o), 64'h1);
    chk("oor_wr_rvalid", 64'(rvalid_o), 64'h0);
    cyc();
    #1;
    chk("oor_err_drop", 64'(err_o), 64'h0);

    do_reset();
    for (int i = 0; i < 15; i++) cyc();
    #1;
    chk("idle15_ls", 64'(bank_ls_o), 64'h0);
    cyc();
    #1;
    chk("idle16_ls", 64'(bank_ls_o), 64'hF);
    req(1'b0, 32'h0000_2010, 64'h0);
    chk("wake_n_gnt", 64'(gnt_o), 64'h0);
    chk("wake_n_en", 64'(bank_en_o), 64'h0);
    chk("wake_n_ls", 64'(bank_ls_o), 64'hF);
    cyc();
    #1;
    chk("wake_n1_gnt", 64'(gnt_o), 64'h0);
    chk("wake_n1_ls", 64'(bank_ls_o), 64'hB);
    chk("wake_n1_en", 64'(bank_en_o), 64'h0);
    cyc();
    #1;
    chk("wake_n2_gnt", 64'(gnt_o), 64'h1);
    chk("wake_n2_en", 64'(bank_en_o), 64'h4);
    chk("wake_n2_row", 64'(bank_addr_o), 64'h2);
    chk("wake_n2_no_rvalid", 64'(rvalid_o), 64'h0);
    cyc();
    en_i = 1'b0;
    #1;
    chk("wake_rvalid", 64'(rvalid_o), 64'h1);
    chk("wake_dat", dat_o, D2);

    req(1'b0, 32'h0000_1000, 64'h0);
    chk("rstw_gnt0", 64'(gnt_o), 64'h0);
    cyc();
    #1;
    chk("rstw_ls_wake", 64'(bank_ls_o), 64'h9);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rstw_ls", 64'(bank_ls_o), 64'h0);
    chk("rstw_gnt", 64'(gnt_o), 64'h1);
    chk("rstw_rvalid", 64'(rvalid_o), 64'h0);
    en_i = 1'b0;
    cyc();
    cyc();
    aresetn = 1'b1;
    req(1'b0, 32'h0000_0008, 64'h0);
    chk("post_rst_en", 64'(bank_en_o), 64'h1);
    cyc();
    en_i = 1'b0;
    #1;
    chk("post_rst_rvalid", 64'(rvalid_o), 64'h1);
    chk("post_rst_dat", dat_o, D0);

    do_reset();
    for (int i = 0; i < 100; i++) begin
      en_i = (i % 10 == 0);
      wen_i = 1'b0;
      addr_i = 32'h0;
      #1;
      chk("per_ls", 64'(bank_ls_o), (i >= 16) ? 64'hE : 64'h0);
      if (i % 10 == 0) chk("per_en", 64'(bank_en_o), 64'h1);
      cyc();
    end
    en_i = 1'b0;

    do_reset();
    for (int i = 0; i < 15; i++) cyc();
    req(1'b0, 32'h0000_0000, 64'h0);
    chk("thr_gnt", 64'(gnt_o), 64'h1);
    chk("thr_en", 64'(bank_en_o), 64'h1);
    cyc();
    en_i = 1'b0;
    #1;
    chk("thr_ls", 64'(bank_ls_o), 64'hE);
    chk("thr_rvalid", 64'(rvalid_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
